// File: rtl/noc_echo_responder.sv
// -----------------------------------------------------------------------------
// noc_echo_responder
//
// NoC-side peer for a single compute tile in verilated benches. One packet
// arriving on channel VC is buffered and sent back to the tile. The returned
// header has dest replaced by the original src and src replaced by MY_ID. All
// other bits are unchanged, and so is the payload. Every other channel is a
// pure sink. Saturating echo and drop counters let a bench check the
// message-passing path end to end.
//
// Ports
//   clk            clock
//   rst_n          synchronous reset, active low
//   noc_in_flit    flit from the tile (type in the top bits)
//   noc_in_valid   per-channel valid from the tile
//   noc_in_ready   per-channel ready to the tile (forced low while in reset)
//   noc_out_flit   registered flit to the tile
//   noc_out_valid  registered per-channel valid to the tile (only VC can be set)
//   noc_out_ready  per-channel ready from the tile
//   echo_count     packets echoed, saturating
//   drop_count     orphan flits and dropped packets, saturating
// -----------------------------------------------------------------------------
module noc_echo_responder #(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int FLIT_TYPE_WIDTH = 2,
    parameter int VCHANNELS       = 3,
    parameter int VC              = 0,
    parameter int MY_ID           = 1,
    parameter int MAX_LEN         = 16,
    localparam int FLIT_WIDTH     = FLIT_TYPE_WIDTH + FLIT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FLIT_WIDTH-1:0] noc_in_flit,
    input  logic [VCHANNELS-1:0]  noc_in_valid,
    output logic [VCHANNELS-1:0]  noc_in_ready,
    output logic [FLIT_WIDTH-1:0] noc_out_flit,
    output logic [VCHANNELS-1:0]  noc_out_valid,
    input  logic [VCHANNELS-1:0]  noc_out_ready,
    output logic [15:0]           echo_count,
    output logic [15:0]           drop_count
);

    // Pointer width must hold the value MAX_LEN itself (full buffer); the
    // address width only needs to cover 0..MAX_LEN-1.
    localparam int PW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [PW-1:0] MAX_LEN_P = PW'(MAX_LEN);

    localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_PAYLOAD = FLIT_TYPE_WIDTH'(0);
    localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_HEADER  = FLIT_TYPE_WIDTH'(1);
    localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_LAST    = FLIT_TYPE_WIDTH'(2);
    localparam logic [FLIT_TYPE_WIDTH-1:0] TYPE_SINGLE  = FLIT_TYPE_WIDTH'(3);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_DROP,
        ST_SEND
    } state_t;

    state_t                  state_reg, state_next;
    logic [PW-1:0]           wptr_reg, wptr_next;
    logic [PW-1:0]           rptr_reg, rptr_next;
    logic                    out_valid_reg, out_valid_next;
    logic [FLIT_WIDTH-1:0]   out_flit_reg;
    logic [15:0]             echo_count_reg;
    logic [15:0]             drop_count_reg;

    logic                    wr_en;
    logic                    load_out;
    logic                    echo_inc;
    logic                    drop_inc;
    logic [FLIT_WIDTH-1:0]   wr_data;
    logic [FLIT_TYPE_WIDTH-1:0] in_type;
    logic                    in_fire;
    logic                    out_fire;

    logic [FLIT_WIDTH-1:0]   flit_mem [MAX_LEN];

    // Per-channel handshake: VC is the echo channel, the rest always sink.
    genvar gi;
    generate
        for (gi = 0; gi < VCHANNELS; gi++) begin : g_chan
            if (gi == VC) begin : g_echo
                assign noc_in_ready[gi]  = rst_n & (state_reg != ST_SEND);
                assign noc_out_valid[gi] = out_valid_reg;
            end else begin : g_sink
                assign noc_in_ready[gi]  = rst_n;
                assign noc_out_valid[gi] = 1'b0;
            end
        end
    endgenerate

    // Handshake bits of the sink-only channels carry no information here.
    logic unused_handshake;
    assign unused_handshake = ^{noc_in_valid, noc_out_ready};

    assign in_type  = noc_in_flit[FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH];
    assign in_fire  = noc_in_valid[VC] & noc_in_ready[VC];
    assign out_fire = out_valid_reg & noc_out_ready[VC];

    // The header is rewritten as it is stored, so the read side is a plain
    // registered memory read.
    always_comb begin
        wr_data = noc_in_flit;
        if (wptr_reg == '0) begin
            wr_data[31:27] = noc_in_flit[23:19];
            wr_data[23:19] = 5'(MY_ID);
        end
    end

    always_comb begin
        state_next     = state_reg;
        wptr_next      = wptr_reg;
        rptr_next      = rptr_reg;
        out_valid_next = out_valid_reg;
        wr_en          = 1'b0;
        load_out       = 1'b0;
        echo_inc       = 1'b0;
        drop_inc       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (in_fire) begin
                    if (in_type == TYPE_HEADER || in_type == TYPE_SINGLE) begin
                        wr_en      = 1'b1;
                        wptr_next  = PW'(1);
                        state_next = (in_type == TYPE_SINGLE) ? ST_SEND : ST_RECV;
                    end else begin
                        drop_inc = 1'b1;  // orphan PAYLOAD/LAST
                    end
                end
            end
            ST_RECV: begin
                if (in_fire) begin
                    if (in_type == TYPE_HEADER || in_type == TYPE_SINGLE) begin
                        drop_inc   = 1'b1;
                        wptr_next  = '0;
                        state_next = ST_DROP;
                    end else if (wptr_reg == MAX_LEN_P) begin
                        // Overflow. If the overflowing flit already closes the
                        // packet there is nothing left to discard.
                        drop_inc   = 1'b1;
                        wptr_next  = '0;
                        state_next = (in_type == TYPE_LAST) ? ST_IDLE : ST_DROP;
                    end else begin
                        wr_en     = 1'b1;
                        wptr_next = wptr_reg + PW'(1);
                        if (in_type == TYPE_LAST) begin
                            state_next = ST_SEND;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (in_fire && in_type == TYPE_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            ST_SEND: begin
                // wptr holds the packet length; rptr is the next flit to load.
                if (!out_valid_reg) begin
                    load_out       = 1'b1;
                    out_valid_next = 1'b1;
                    rptr_next      = rptr_reg + PW'(1);
                end else if (out_fire) begin
                    if (rptr_reg == wptr_reg) begin
                        out_valid_next = 1'b0;
                        echo_inc       = 1'b1;
                        rptr_next      = '0;
                        wptr_next      = '0;
                        state_next     = ST_IDLE;
                    end else begin
                        load_out  = 1'b1;
                        rptr_next = rptr_reg + PW'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            flit_mem[wptr_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_reg       <= '0;
            rptr_reg       <= '0;
            out_valid_reg  <= 1'b0;
            out_flit_reg   <= '0;
            echo_count_reg <= '0;
            drop_count_reg <= '0;
        end else begin
            wptr_reg      <= wptr_next;
            rptr_reg      <= rptr_next;
            out_valid_reg <= out_valid_next;
            if (load_out) begin
                out_flit_reg <= flit_mem[rptr_reg[AW-1:0]];
            end
            if (echo_inc && echo_count_reg != 16'hFFFF) begin
                echo_count_reg <= echo_count_reg + 16'd1;
            end
            if (drop_inc && drop_count_reg != 16'hFFFF) begin
                drop_count_reg <= drop_count_reg + 16'd1;
            end
        end
    end

    assign noc_out_flit = out_flit_reg;
    assign echo_count   = echo_count_reg;
    assign drop_count   = drop_count_reg;

endmodule

// File: tb/tb_noc_echo_responder.sv
// -----------------------------------------------------------------------------
// tb_noc_echo_responder
//
// Self-checking bench for noc_echo_responder. Fixed vectors come from a table,
// the multi-cycle corner cases are written out by hand, and random items are
// checked against a packet-level model of the echo/drop rules.
// -----------------------------------------------------------------------------
module tb_noc_echo_responder;

    localparam int MAX_LEN = 16;
    localparam logic [4:0] MY_ID = 5'd1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [33:0] noc_in_flit;
    logic [2:0]  noc_in_valid;
    logic [2:0]  noc_in_ready;
    logic [33:0] noc_out_flit;
    logic [2:0]  noc_out_valid;
    logic [2:0]  noc_out_ready;
    logic [15:0] echo_count;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    noc_echo_responder #(
        .FLIT_DATA_WIDTH(32), .FLIT_TYPE_WIDTH(2), .VCHANNELS(3),
        .VC(0), .MY_ID(1), .MAX_LEN(MAX_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .noc_in_flit(noc_in_flit), .noc_in_valid(noc_in_valid),
        .noc_in_ready(noc_in_ready),
        .noc_out_flit(noc_out_flit), .noc_out_valid(noc_out_valid),
        .noc_out_ready(noc_out_ready),
        .echo_count(echo_count), .drop_count(drop_count)
    );

    typedef enum int {K_SINGLE, K_PKT, K_ORPHAN} kind_e;

    typedef struct {
        string       name;
        kind_e       kind;
        int          ch;
        int          len;
        logic [33:0] first;
        int          rdy_mode;   // 0 always ready, 1 toggle, 2 random
        logic [33:0] exp_first;
        int          exp_nout;
        int          exp_echo_inc;
        int          exp_drop_inc;
    } vec_t;

    vec_t        vecs[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_echo = 0;
    int          exp_drop = 0;
    int          rdy_mode = 0;
    logic [33:0] got[$];
    logic        hold_pending = 1'b0;
    logic [33:0] held_flit;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Output ready driver, changes just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: noc_out_ready = 3'b111;
            1: noc_out_ready = {2'($urandom), ~noc_out_ready[0]};
            default: noc_out_ready = 3'($urandom);
        endcase
    end

    // Output collector: records each transfer and checks stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pending) begin
                check("stall_valid_held", 64'(noc_out_valid[0]), 64'd1);
                check("stall_flit_held", 64'(noc_out_flit), 64'(held_flit));
            end
            if (noc_out_valid[2:1] != 2'b00) begin
                check("nonvc_out_valid", 64'(noc_out_valid[2:1]), 64'd0);
            end
            if (noc_out_valid[0] && noc_out_ready[0]) begin
                got.push_back(noc_out_flit);
            end
            hold_pending = noc_out_valid[0] && !noc_out_ready[0];
            held_flit    = noc_out_flit;
        end else begin
            hold_pending = 1'b0;
        end
    end

    function automatic logic [33:0] rewrite(input logic [33:0] h);
        return {h[33:32], h[23:19], h[26:24], MY_ID, h[18:0]};
    endfunction

    function automatic logic [31:0] pdata(input int i);
        case (i)
            1:       return 32'hA5A5_A5A5;
            2:       return 32'h5A5A_5A5A;
            default: return 32'hC0DE_0000 | 32'(i);
        endcase
    endfunction

    // Packet-level reference: what the tile should see for one stimulus item.
    task automatic model_item(input kind_e kind, input int ch, input int len,
                              input logic [33:0] first, output logic [33:0] exp_first,
                              output int nout, output int e_inc, output int d_inc);
        exp_first = '0; nout = 0; e_inc = 0; d_inc = 0;
        if (ch != 0) return;
        case (kind)
            K_SINGLE: begin nout = 1; e_inc = 1; exp_first = rewrite(first); end
            K_PKT: begin
                if (len <= MAX_LEN) begin
                    nout = len; e_inc = 1; exp_first = rewrite(first);
                end else begin
                    d_inc = 1;
                end
            end
            default: d_inc = 1;
        endcase
    endtask

    task automatic send_flit(input int ch, input logic [33:0] f);
        int waited = 0;
        noc_in_flit      = f;
        noc_in_valid     = '0;
        noc_in_valid[ch] = 1'b1;
        forever begin
            @(negedge clk);
            if (noc_in_ready[ch]) break;
            waited++;
            if (waited > 300) begin
                check("in_ready_timeout", 64'(waited), 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
        noc_in_valid = '0;
    endtask

    task automatic finish_item(input string name, input logic [33:0] sent[$],
                               input logic [33:0] exp_first, input int nout,
                               input int e_inc, input int d_inc);
        int t = 0;
        while (got.size() < nout && t < 400) begin @(negedge clk); t++; end
        repeat (4) @(negedge clk);
        exp_echo += e_inc;
        exp_drop += d_inc;
        check({name, " nout"}, 64'(got.size()), 64'(nout));
        for (int i = 0; i < got.size() && i < nout; i++) begin
            check($sformatf("%s flit%0d", name, i), 64'(got[i]),
                  64'((i == 0) ? exp_first : sent[i]));
        end
        check({name, " valid_idle"}, 64'(noc_out_valid), 64'd0);
        check({name, " echo_count"}, 64'(echo_count), 64'(exp_echo));
        check({name, " drop_count"}, 64'(drop_count), 64'(exp_drop));
        $display("item %-20s out=%0d echo=%0d drop=%0d", name, got.size(), echo_count, drop_count);
        @(posedge clk); #1;
    endtask

    task automatic build_item(input kind_e kind, input int len, input logic [33:0] first,
                              input bit rnd, output logic [33:0] sent[$]);
        sent.delete();
        sent.push_back(first);
        if (kind == K_PKT) begin
            for (int i = 1; i < len - 1; i++) begin
                sent.push_back({2'b00, rnd ? 32'($urandom) : pdata(i)});
            end
            sent.push_back({2'b10, rnd ? 32'($urandom) : 32'hDEAD_BEEF});
        end
    endtask

    task automatic run_item(input string name, input kind_e kind, input int ch, input int len,
                            input logic [33:0] first, input int mode, input bit rnd,
                            input logic [33:0] exp_first, input int nout,
                            input int e_inc, input int d_inc);
        logic [33:0] sent[$];
        got.delete();
        rdy_mode = mode;
        build_item(kind, len, first, rnd, sent);
        foreach (sent[i]) send_flit(ch, sent[i]);
        finish_item(name, sent, exp_first, nout, e_inc, d_inc);
    endtask

    task automatic add_vec(input string name, input kind_e kind, input int ch, input int len,
                           input logic [33:0] first, input int mode, input logic [33:0] exp_first,
                           input int nout, input int e_inc, input int d_inc);
        vec_t v;
        v.name = name; v.kind = kind; v.ch = ch; v.len = len; v.first = first;
        v.rdy_mode = mode; v.exp_first = exp_first; v.exp_nout = nout;
        v.exp_echo_inc = e_inc; v.exp_drop_inc = d_inc;
        vecs.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] sent[$];
        logic [33:0] ef;
        int          nout, e_inc, d_inc, t;

        // header A: dest 2, class 5, src 3 -> dest 3, src 1
        // header B: dest 7, class 2, src 9 -> dest 9, src 1
        add_vec("single_vc0",        K_SINGLE, 0, 1,  34'h3_1518_1234, 0, 34'h3_1D08_1234, 1, 1, 0);
        add_vec("pkt4",              K_PKT,    0, 4,  34'h1_1518_1234, 0, 34'h1_1D08_1234, 4, 1, 0);
        add_vec("pkt4_toggle",       K_PKT,    0, 4,  34'h1_1518_1234, 1, 34'h1_1D08_1234, 4, 1, 0);
        add_vec("pkt17_overflow",    K_PKT,    0, 17, 34'h1_3A48_0000, 0, 34'h0,           0, 0, 1);
        add_vec("single_after_drop", K_SINGLE, 0, 1,  34'h3_3A48_0000, 0, 34'h3_4A08_0000, 1, 1, 0);
        add_vec("orphan_payload",    K_ORPHAN, 0, 1,  34'h0_1234_5678, 0, 34'h0,           0, 0, 1);
        add_vec("orphan_last",       K_ORPHAN, 0, 1,  34'h2_0BAD_F00D, 0, 34'h0,           0, 0, 1);
        add_vec("single_vc1",        K_SINGLE, 1, 1,  34'h3_1518_1234, 0, 34'h0,           0, 0, 0);
        add_vec("pkt16_max",         K_PKT,    0, 16, 34'h1_3A48_0000, 2, 34'h1_4A08_0000, 16, 1, 0);
        add_vec("pkt18_overflow",    K_PKT,    0, 18, 34'h1_1518_1234, 0, 34'h0,           0, 0, 1);
        add_vec("pkt2_toggle",       K_PKT,    0, 2,  34'h1_3A48_0000, 1, 34'h1_4A08_0000, 2, 1, 0);
        add_vec("pkt3_vc2",          K_PKT,    2, 3,  34'h1_1518_1234, 0, 34'h0,           0, 0, 0);

        rst_n         = 1'b0;
        noc_in_flit   = '0;
        noc_in_valid  = '0;
        noc_out_ready = 3'b111;
        repeat (3) @(negedge clk);
        check("reset out_valid", 64'(noc_out_valid), 64'd0);
        check("reset out_flit", 64'(noc_out_flit), 64'd0);
        check("reset in_ready", 64'(noc_in_ready), 64'd0);
        check("reset echo_count", 64'(echo_count), 64'd0);
        check("reset drop_count", 64'(drop_count), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle in_ready", 64'(noc_in_ready), 64'd7);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_item(vecs[i].name, vecs[i].kind, vecs[i].ch, vecs[i].len, vecs[i].first,
                     vecs[i].rdy_mode, 1'b0, vecs[i].exp_first, vecs[i].exp_nout,
                     vecs[i].exp_echo_inc, vecs[i].exp_drop_inc);
        end

        // HEADER inside a packet: the whole stream up to the next LAST is lost.
        got.delete();
        rdy_mode = 0;
        send_flit(0, 34'h1_1518_1234);
        send_flit(0, 34'h0_1111_1111);
        send_flit(0, 34'h1_3A48_0000);
        send_flit(0, 34'h0_2222_2222);
        send_flit(0, 34'h2_3333_3333);
        sent.delete();
        finish_item("header_in_recv", sent, 34'h0, 0, 0, 1);
        run_item("single_after_err", K_SINGLE, 0, 1, 34'h3_1518_1234, 0, 1'b0,
                 34'h3_1D08_1234, 1, 1, 0);

        // Reset while an echo is draining.
        got.delete();
        rdy_mode = 0;
        build_item(K_PKT, 4, 34'h1_1518_1234, 1'b0, sent);
        foreach (sent[i]) send_flit(0, sent[i]);
        t = 0;
        while (got.size() < 2 && t < 100) begin @(negedge clk); t++; end
        check("midsend reached 2 flits", 64'(got.size() >= 2), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midsend in_ready gated", 64'(noc_in_ready), 64'd0);
        @(negedge clk);
        check("midsend out_valid", 64'(noc_out_valid), 64'd0);
        check("midsend out_flit", 64'(noc_out_flit), 64'd0);
        check("midsend echo_count", 64'(echo_count), 64'd0);
        check("midsend drop_count", 64'(drop_count), 64'd0);
        $display("item %-20s echo=%0d drop=%0d", "reset_mid_send", echo_count, drop_count);
        @(posedge clk); #1;
        rst_n    = 1'b1;
        exp_echo = 0;
        exp_drop = 0;
        run_item("single_after_reset", K_SINGLE, 0, 1, 34'h3_3A48_0000, 0, 1'b0,
                 34'h3_4A08_0000, 1, 1, 0);

        // Random items against the packet-level model.
        for (int n = 0; n < 30; n++) begin
            kind_e       k;
            int          ch, len, mode;
            logic [33:0] first;
            k     = kind_e'($urandom_range(0, 2));
            ch    = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
            len   = (k == K_PKT) ? $urandom_range(2, 20) : 1;
            mode  = $urandom_range(0, 2);
            first = {2'b00, 32'($urandom)};
            case (k)
                K_SINGLE: first[33:32] = 2'b11;
                K_PKT:    first[33:32] = 2'b01;
                default:  first[33:32] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
            endcase
            model_item(k, ch, len, first, ef, nout, e_inc, d_inc);
            run_item($sformatf("rand%0d", n), k, ch, len, first, mode, 1'b1,
                     ef, nout, e_inc, d_inc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
